// File: rtl/paralelo_serial_pkg.sv
`default_nettype none
// ============================================================================
// Package     : paralelo_serial_pkg
// Description : Constants and types shared by the blue-lane serializer and
//               deserializer: word width, comma (idle/alignment) symbol,
//               number of commas needed for lock, and receiver FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package paralelo_serial_pkg;

  localparam int         SP_WIDTH       = 8;
  localparam logic [7:0] SP_COMMA       = 8'hBC;
  localparam int         SP_COMMA_COUNT = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_e;

endpackage
`default_nettype wire

// File: rtl/sp_comma_detect.sv
`default_nettype none
// ============================================================================
// Module      : sp_comma_detect
// Description : Serial shift register and comma compare. Presents the word
//               formed by the bits already shifted in plus the bit arriving
//               this cycle, and flags when that word equals the comma.
// Revision    : 1.0 - initial release
// Ports       : clk_i   - bit clock
//               rst_i   - synchronous active-high reset
//               data_i  - serial input bit, MSB of each word first
//               nxt_o   - word completed if this cycle's bit were the LSB
//               comma_o - nxt_o equals COMMA
// ============================================================================
module sp_comma_detect
  import paralelo_serial_pkg::*;
#(
  parameter int               WIDTH = SP_WIDTH,
  parameter logic [WIDTH-1:0] COMMA = SP_COMMA
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             comma_o
);

  // Only the newest WIDTH-1 bits are ever needed: the oldest bit falls off
  // the word as soon as the next one arrives, so it is not stored.
  logic [WIDTH-2:0] sr_q;

  assign nxt_o   = {sr_q, data_i};
  assign comma_o = (nxt_o == COMMA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= nxt_o[WIDTH-2:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_paralelo_azul.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_azul
// Description : Blue-lane serial-to-parallel receiver. Finds byte alignment
//               on the comma idle symbol, requires COMMA_COUNT aligned commas
//               before declaring the link active, then delivers each
//               non-comma word with a valid flag once every WIDTH cycles.
// Revision    : 1.0 - initial release
// Ports       : clk32_f     - bit clock (rising edge)
//               reset       - synchronous active-high reset
//               data_in     - serial bit stream, MSB first
//               data_out    - last received data word
//               valid_out   - data_out holds a non-comma word from ACTIVE
//               active      - link aligned and locked
//               byte_strobe - one-cycle pulse after each aligned word
// ============================================================================
module serial_paralelo_azul
  import paralelo_serial_pkg::*;
#(
  parameter int               WIDTH       = SP_WIDTH,
  parameter logic [WIDTH-1:0] COMMA       = SP_COMMA,
  parameter int               COMMA_COUNT = SP_COMMA_COUNT
) (
  input  logic             clk32_f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             byte_strobe
);

  localparam int                BIT_W    = $clog2(WIDTH);
  localparam int                BC_W     = $clog2(COMMA_COUNT + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BC_W-1:0]   BC_FULL  = BC_W'(COMMA_COUNT);
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(COMMA_COUNT - 1);

  logic [WIDTH-1:0] nxt;
  logic             is_comma;

  sp_comma_detect #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_comma_detect (
    .clk_i   (clk32_f),
    .rst_i   (reset),
    .data_i  (data_in),
    .nxt_o   (nxt),
    .comma_o (is_comma)
  );

  sp_state_e        state_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BC_W-1:0]  bc_cnt_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_out_q;
  logic             active_q;
  logic             byte_strobe_q;

  logic             word_done;
  logic [BIT_W-1:0] bit_cnt_d;

  assign word_done = (bit_cnt_q == BIT_LAST);
  assign bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;

  always_ff @(posedge clk32_f) begin
    if (reset) begin
      state_q       <= HUNT;
      bit_cnt_q     <= '0;
      bc_cnt_q      <= '0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      active_q      <= 1'b0;
      byte_strobe_q <= 1'b0;
    end else begin
      byte_strobe_q <= 1'b0;
      case (state_q)
        HUNT: begin
          // Bit-by-bit search; a match defines the word boundary.
          bit_cnt_q <= '0;
          if (is_comma) begin
            state_q  <= SYNC;
            bc_cnt_q <= BC_W'(1);
          end
        end
        SYNC: begin
          bit_cnt_q <= bit_cnt_d;
          if (word_done) begin
            if (is_comma) begin
              byte_strobe_q <= 1'b1;
              if (bc_cnt_q != BC_FULL) begin
                bc_cnt_q <= bc_cnt_q + 1'b1;
              end
              if (bc_cnt_q >= BC_LAST) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              // Broken comma run: drop the strobe since we leave alignment.
              state_q  <= HUNT;
              bc_cnt_q <= '0;
            end
          end
        end
        ACTIVE: begin
          // Locked until reset; data bytes never trigger realignment.
          bit_cnt_q <= bit_cnt_d;
          if (word_done) begin
            byte_strobe_q <= 1'b1;
            if (is_comma) begin
              valid_out_q <= 1'b0;
            end else begin
              data_out_q  <= nxt;
              valid_out_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign active      = active_q;
  assign byte_strobe = byte_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_azul.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_azul
// Description : Directed self-checking bench for serial_paralelo_azul.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_azul;

  logic       clk32_f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  int errors = 0;
  int checks = 0;

  always #5 clk32_f = ~clk32_f;

  serial_paralelo_azul dut (
    .clk32_f     (clk32_f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .byte_strobe (byte_strobe)
  );

  // Sends the top n bits of b, MSB first; returns #1 after the last edge.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      data_in = b[i];
      @(posedge clk32_f);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk32_f);
    #1;
    reset = 1'b0;
  endtask

  // Brings the receiver to ACTIVE with four aligned commas.
  task automatic lock_link();
    do_reset();
    repeat (4) send_byte(8'hBC);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk32_f);
      #1;
      checks++;
      if ({data_out, valid_out, active, byte_strobe} !== 11'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got d=%h v=%b a=%b s=%b want all 0",
                 c, data_out, valid_out, active, byte_strobe);
      end
    end
    reset   = 1'b0;
    data_in = 1'($urandom_range(0, 1));
    @(posedge clk32_f);
    #1;
    checks++;
    if ({data_out, valid_out, active, byte_strobe} !== 11'd0) begin
      errors++;
      $display("FAIL reset_release got d=%h v=%b a=%b s=%b want all 0",
               data_out, valid_out, active, byte_strobe);
    end
  endtask

  task automatic test_stream();
    logic [7:0] d [4];
    logic [7:0] prev;
    d = '{8'hFF, 8'hAA, 8'h25, 8'hEE};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send_byte(8'hBC);
      checks++;
      if (active !== (k == 3)) begin
        errors++;
        $display("FAIL stream_active comma=%0d got %b want %b", k + 1, active, (k == 3));
      end
    end
    checks++;
    if (byte_strobe !== 1'b1) begin
      errors++;
      $display("FAIL stream_strobe_lock got %b want 1", byte_strobe);
    end
    prev = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_bits(d[i], 4);
      checks++;
      if ({valid_out, data_out} !== {(i > 0), prev}) begin
        errors++;
        $display("FAIL stream_midword i=%0d got v=%b d=%h want v=%b d=%h",
                 i, valid_out, data_out, (i > 0), prev);
      end
      send_bits({d[i][3:0], 4'h0}, 4);
      checks++;
      if ({valid_out, data_out, active} !== {1'b1, d[i], 1'b1}) begin
        errors++;
        $display("FAIL stream_word i=%0d got v=%b d=%h a=%b want v=1 d=%h a=1",
                 i, valid_out, data_out, active, d[i]);
      end
      prev = d[i];
    end
    send_byte(8'hBC);
    checks++;
    if ({valid_out, data_out} !== {1'b0, 8'hEE}) begin
      errors++;
      $display("FAIL stream_idle got v=%b d=%h want v=0 d=ee", valid_out, data_out);
    end
  endtask

  task automatic test_midstream_align();
    do_reset();
    send_bits(8'b1010_0000, 3);
    repeat (3) send_byte(8'hBC);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL align_early_active got %b want 0", active);
    end
    send_byte(8'hBC);
    send_byte(8'h11);
    checks++;
    if ({active, valid_out, data_out} !== {1'b1, 1'b1, 8'h11}) begin
      errors++;
      $display("FAIL align_data got a=%b v=%b d=%h want a=1 v=1 d=11",
               active, valid_out, data_out);
    end
  endtask

  task automatic test_broken_run();
    do_reset();
    repeat (3) send_byte(8'hBC);
    send_byte(8'h11);
    checks++;
    if ({active, valid_out} !== 2'b00) begin
      errors++;
      $display("FAIL broken_after11 got a=%b v=%b want 0 0", active, valid_out);
    end
    repeat (3) send_byte(8'hBC);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL broken_three_fresh got %b want 0", active);
    end
    send_byte(8'hBC);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL broken_four_fresh got %b want 1", active);
    end
  endtask

  task automatic test_active_comma();
    logic [7:0] s [3];
    logic [2:0] v_exp;
    logic [7:0] d_exp [3];
    s     = '{8'h11, 8'hBC, 8'h00};
    v_exp = 3'b101;
    d_exp = '{8'h11, 8'h11, 8'h00};
    lock_link();
    for (int i = 0; i < 3; i++) begin
      send_byte(s[i]);
      checks++;
      if ({valid_out, data_out, byte_strobe} !== {v_exp[2 - i], d_exp[i], 1'b1}) begin
        errors++;
        $display("FAIL active_seq i=%0d got v=%b d=%h s=%b want v=%b d=%h s=1",
                 i, valid_out, data_out, byte_strobe, v_exp[2 - i], d_exp[i]);
      end
    end
    data_in = 1'b0;
    @(posedge clk32_f);
    #1;
    checks++;
    if (byte_strobe !== 1'b0) begin
      errors++;
      $display("FAIL strobe_width got %b want 0", byte_strobe);
    end
  endtask

  task automatic test_reset_midword();
    lock_link();
    send_byte(8'h3C);
    send_bits(8'h5A, 4);
    reset   = 1'b1;
    data_in = 1'b1;
    @(posedge clk32_f);
    #1;
    checks++;
    if ({data_out, valid_out, active, byte_strobe} !== 11'd0) begin
      errors++;
      $display("FAIL midword_reset got d=%h v=%b a=%b s=%b want all 0",
               data_out, valid_out, active, byte_strobe);
    end
    reset = 1'b0;
    repeat (3) send_byte(8'hBC);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL midword_relock_early got %b want 0", active);
    end
    send_byte(8'hBC);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL midword_relock got %b want 1", active);
    end
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    test_reset();
    test_stream();
    test_midstream_align();
    test_broken_run();
    test_active_comma();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
